// File: rtl/sram_master_pkg.sv
// sram_master_pkg
//   Shared definitions for the SRAM burst master: default bus widths, the
//   master FSM state encoding and the request descriptor carried from the
//   valid/ready request port into the beat counter.
package sram_master_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    TURN
  } state_t;

  // One burst request as offered on the request port; len is beats-1.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } req_t;

endpackage

// File: rtl/sram_beat_counter.sv
// sram_beat_counter
//   Loadable beat counter plus address incrementer for one burst.
//   i_load latches the burst start address and beats-1; every i_step moves to
//   the next beat. The address wraps modulo the RAM depth simply by the
//   natural overflow of the ADDR_WIDTH-bit register.
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   i_load       latch i_base / i_len (takes priority over i_step)
//   i_step       advance to the next beat
//   i_base       burst start address
//   i_len        beats-1
//   o_curAddr    address of the beat currently on the bus
//   o_isLast     current beat is the final one of the burst
module sram_beat_counter #(
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic [ADDR_WIDTH-1:0] o_curAddr,
  output logic                  o_isLast
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remain;

  // r_remain counts the beats still to go after the current one, so the
  // final beat is the one where it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_remain <= i_len;
    end else if (i_step) begin
      r_addr   <= r_addr + 1'b1;
      r_remain <= r_remain - 1'b1;
    end
  end

  assign o_curAddr = r_addr;
  assign o_isLast  = (r_remain == '0);

endmodule

// File: rtl/sram_burst_master.sv
// sram_burst_master
//   Bus initiator for a single-port RAM with a shared tri-state data bus.
//   Accepts valid/ready burst requests, sequences cs/we/oe/addr, pushes write
//   data onto the bus and returns read data as a response stream.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_we/req_addr/req_len    burst direction, start address, beats-1
//   wr_data/wr_pop             write beat data, consumed when wr_pop is high
//   rsp_valid/rsp_data/rsp_last read beat stream, no backpressure
//   mem_cs/mem_we/mem_oe       RAM controls
//   mem_addr                   RAM address
//   mem_data                   shared bus, driven by the master only in WRITE
module sram_burst_master
  import sram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int LEN_WIDTH  = LEN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_pop,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_t r_state;
  state_t w_next;
  req_t   w_req;
  logic   w_load;
  logic   w_step;
  logic   w_isLast;

  logic   r_reqReady;
  logic   r_memCs;
  logic   r_memWe;
  logic   r_memOe;
  logic   r_wrPop;
  logic   r_drive;

  logic                  r_pend;
  logic                  r_pendLast;
  logic                  r_rspValid;
  logic                  r_rspLast;
  logic [DATA_WIDTH-1:0] r_rspData;

  assign w_req = '{we: req_we, addr: req_addr, len: req_len};

  // Beat counter: its address register is mem_addr directly, so the address
  // for beat k is already on the bus in the cycle that beat k is issued.
  sram_beat_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_beatCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_base   (w_req.addr),
    .i_len    (w_req.len),
    .o_curAddr(mem_addr),
    .o_isLast (w_isLast)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. A request is only seen in IDLE, so a request offered
  // while busy simply waits with ready low until the burst completes.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_load = 1'b1;
          w_next = w_req.we ? WRITE : READ;
        end
      end
      WRITE: begin
        w_step = 1'b1;
        if (w_isLast) w_next = IDLE;
      end
      READ: begin
        w_step = 1'b1;
        if (w_isLast) w_next = DRAIN;
      end
      DRAIN:   w_next = TURN;
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus control outputs are registered from the next state so that each
  // cycle's cs/we/oe/drive always belong to the state occupying that cycle.
  // oe stays high through DRAIN for the final read beat, and TURN drops it
  // one full cycle before any following write can drive the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reqReady <= 1'b1;
      r_memCs    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memOe    <= 1'b0;
      r_wrPop    <= 1'b0;
      r_drive    <= 1'b0;
    end else begin
      r_reqReady <= (w_next == IDLE);
      r_memCs    <= (w_next == WRITE) || (w_next == READ);
      r_memWe    <= (w_next == WRITE);
      r_memOe    <= (w_next == READ) || (w_next == DRAIN);
      r_wrPop    <= (w_next == WRITE);
      r_drive    <= (w_next == WRITE);
    end
  end

  // Read response pipeline. r_pend marks the cycle in which the RAM drives
  // data for the address issued one cycle earlier; that data is captured at
  // the end of the cycle, giving a response two cycles after its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_pendLast <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspLast  <= 1'b0;
      r_rspData  <= '0;
    end else begin
      r_pend     <= r_memCs && !r_memWe;
      r_pendLast <= r_memCs && !r_memWe && w_isLast;
      r_rspValid <= r_pend;
      r_rspLast  <= r_pendLast;
      if (r_pend) r_rspData <= mem_data;
    end
  end

  assign mem_data  = r_drive ? wr_data : {DATA_WIDTH{1'bz}};

  assign req_ready = r_reqReady;
  assign mem_cs    = r_memCs;
  assign mem_we    = r_memWe;
  assign mem_oe    = r_memOe;
  assign wr_pop    = r_wrPop;
  assign rsp_valid = r_rspValid;
  assign rsp_last  = r_rspLast;
  assign rsp_data  = r_rspData;

endmodule
